ui_input_mgr: RTL and testbench

- User-input side of the Nexys A7 front panel: the opposite direction to the display manager.
- Synchronizes and debounces the five push-buttons and 16 slide switches, then turns button presses into registered control values.
- Outputs are the values the display manager shows: gen_mod, prog and data_2, plus a one-cycle data_valid strobe.
- Sits between board pins and the core, in the same clock domain as the display path.

---
 rtl/ui_input_mgr.sv | 112 +++++++++++
 tb/tb_ui_input_mgr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ui_input_mgr.sv
// Front-panel input manager: synchronizes and debounces the Nexys A7 buttons and
// switches, then turns accepted presses into gen_mod, prog and data_2 updates.
module ui_input_mgr #(
  parameter int DEB_CYCLES = 1000000,
  parameter int PROG_MAX   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_c,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_r,
  input  logic        btn_l,
  input  logic [15:0] sw,
  output logic [1:0]  gen_mod,
  output logic [2:0]  prog,
  output logic [15:0] data_2,
  output logic        data_valid
);

  localparam logic [19:0] CNT_LAST = 20'(DEB_CYCLES - 1);
  localparam logic [2:0]  PROG_TOP = 3'(PROG_MAX);

  // Button bit order: 0=centre, 1=up, 2=down, 3=right, 4=left.
  logic [4:0]  w_btnRaw;
  logic [4:0]  w_press;
  logic [4:0]  r_btnSync1;
  logic [4:0]  r_btnSync2;
  logic [15:0] r_swSync1;
  logic [15:0] r_swSync2;
  logic [19:0] r_cnt [5];
  logic [4:0]  r_st;
  logic [4:0]  r_stQ;
  logic [1:0]  r_genMod;
  logic [2:0]  r_prog;
  logic [15:0] r_data2;
  logic        r_dataValid;

  assign w_btnRaw = {btn_l, btn_r, btn_d, btn_u, btn_c};
  assign w_press  = r_st & ~r_stQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_btnSync1 <= '0;
      r_btnSync2 <= '0;
      r_swSync1  <= '0;
      r_swSync2  <= '0;
    end else begin
      r_btnSync1 <= w_btnRaw;
      r_btnSync2 <= r_btnSync1;
      r_swSync1  <= sw;
      r_swSync2  <= r_swSync1;
    end
  end

  // A new level is accepted only after it has differed from st for DEB_CYCLES
  // consecutive cycles; any return to the stable level restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_st  <= '0;
      r_stQ <= '0;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stQ <= r_st;
      for (int i = 0; i < 5; i++) begin
        if (r_btnSync2[i] != r_st[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_st[i]  <= r_btnSync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 20'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_genMod    <= '0;
      r_prog      <= '0;
      r_data2     <= '0;
      r_dataValid <= 1'b0;
    end else begin
      r_dataValid <= w_press[0];
      if (w_press[0]) begin
        r_data2 <= r_swSync2;
      end
      // Opposing presses in the same cycle cancel out.
      case (w_press[2:1])
        2'b01:   r_prog <= (r_prog == PROG_TOP) ? 3'd0 : r_prog + 3'd1;
        2'b10:   r_prog <= (r_prog == 3'd0) ? PROG_TOP : r_prog - 3'd1;
        default: r_prog <= r_prog;
      endcase
      case (w_press[4:3])
        2'b01:   r_genMod <= r_genMod + 2'd1;
        2'b10:   r_genMod <= r_genMod - 2'd1;
        default: r_genMod <= r_genMod;
      endcase
    end
  end

  assign gen_mod    = r_genMod;
  assign prog       = r_prog;
  assign data_2     = r_data2;
  assign data_valid = r_dataValid;

endmodule

// File: tb/tb_ui_input_mgr.sv
// Self-checking bench for ui_input_mgr: directed front-panel scenarios plus random
// button/switch activity, compared every cycle against a run-length reference model.
module tb_ui_input_mgr;

  localparam int DEB = 4;
  localparam int PMAX = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btns = '0;
  logic [15:0] swIn = '0;
  logic [1:0]  gen_mod;
  logic [2:0]  prog;
  logic [15:0] data_2;
  logic        data_valid;

  int checks = 0;
  int failures = 0;
  int edgeNo = 0;

  // Reference model state: raw history, stable levels, and consecutive-difference runs.
  logic [4:0]  mBtnH1, mBtnH2, mSt, mStPrev;
  logic [15:0] mSwH1, mSwH2, mData;
  int          mRun [5];
  int          mProg, mGen;
  logic        mValid;

  ui_input_mgr #(.DEB_CYCLES(DEB), .PROG_MAX(PMAX)) dut (
    .clock(clock), .reset(reset),
    .btn_c(btns[0]), .btn_u(btns[1]), .btn_d(btns[2]), .btn_r(btns[3]), .btn_l(btns[4]),
    .sw(swIn), .gen_mod(gen_mod), .prog(prog), .data_2(data_2), .data_valid(data_valid)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h edge=%0d", tag, observed, expected, edgeNo);
    end
  endtask

  task automatic modelEdge(input logic rst, input logic [4:0] b, input logic [15:0] s);
    logic [4:0] press;
    if (rst) begin
      mBtnH1 = '0; mBtnH2 = '0; mSwH1 = '0; mSwH2 = '0;
      mSt = '0; mStPrev = '0; mData = '0; mValid = 1'b0;
      mProg = 0; mGen = 0;
      for (int i = 0; i < 5; i++) mRun[i] = 0;
    end else begin
      press = mSt & ~mStPrev;
      mValid = press[0];
      if (press[0]) mData = mSwH2;
      if (press[1] && !press[2]) mProg = (mProg + 1) % (PMAX + 1);
      if (press[2] && !press[1]) mProg = (mProg + PMAX) % (PMAX + 1);
      if (press[3] && !press[4]) mGen = (mGen + 1) % 4;
      if (press[4] && !press[3]) mGen = (mGen + 3) % 4;
      mStPrev = mSt;
      for (int i = 0; i < 5; i++) begin
        if (mBtnH2[i] != mSt[i]) begin
          mRun[i]++;
          if (mRun[i] == DEB) begin
            mSt[i] = mBtnH2[i];
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      mBtnH2 = mBtnH1; mBtnH1 = b;
      mSwH2 = mSwH1;   mSwH1 = s;
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic [4:0] b, input logic [15:0] s);
    reset = rst; btns = b; swIn = s;
    edgeNo++;
    @(posedge clock);
    modelEdge(rst, b, s);
    @(negedge clock);
    checkOutput("prog", 16'(prog), 16'(mProg));
    checkOutput("gen_mod", 16'(gen_mod), 16'(mGen));
    checkOutput("data_2", data_2, mData);
    checkOutput("data_valid", 16'(data_valid), 16'(mValid));
  endtask

  task automatic holdCycles(input int n, input logic [4:0] b, input logic [15:0] s);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, b, s);
  endtask

  task automatic pressButton(input logic [4:0] b, input logic [15:0] s);
    holdCycles(DEB + 4, b, s);
    holdCycles(DEB + 4, 5'b0, s);
  endtask

  int validCount, changeEdge, kRise, relEdge, startVal, lastProg;
  logic [4:0] rb;

  initial begin
    @(negedge clock);
    // Reset with buttons held: outputs stay zero throughout.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'b11111, 16'h5A5A);
      checkOutput("rst_prog", 16'(prog), 16'h0);
      checkOutput("rst_valid", 16'(data_valid), 16'h0);
      checkOutput("rst_data", data_2, 16'h0);
    end
    validCount = 0;
    for (int i = 0; i < DEB + 10; i++) begin
      applyStimulus(1'b0, 5'b01011, 16'h5A5A);
      if (data_valid) validCount++;
    end
    checkOutput("held_prog", 16'(prog), 16'h1);
    checkOutput("held_gen", 16'(gen_mod), 16'h1);
    checkOutput("held_data", data_2, 16'h5A5A);
    checkOutput("held_pulses", 16'(validCount), 16'h1);
    holdCycles(DEB + 4, 5'b0, 16'h5A5A);

    // Bounce on btn_u, then a steady hold.
    applyStimulus(1'b0, 5'b00010, 16'h0);
    applyStimulus(1'b0, 5'b00000, 16'h0);
    applyStimulus(1'b0, 5'b00010, 16'h0);
    applyStimulus(1'b0, 5'b00000, 16'h0);
    kRise = edgeNo + 1;
    changeEdge = -1;
    lastProg = int'(prog);
    validCount = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 5'b00010, 16'h0);
      if (int'(prog) != lastProg) begin
        validCount++;
        if (changeEdge < 0) changeEdge = edgeNo;
      end
      lastProg = int'(prog);
    end
    checkOutput("bounce_latency", 16'(changeEdge - kRise), 16'(DEB + 2));
    checkOutput("bounce_changes", 16'(validCount), 16'h1);
    checkOutput("bounce_prog", 16'(prog), 16'h2);
    holdCycles(DEB + 4, 5'b0, 16'h0);

    // Wrap-around in both directions.
    startVal = int'(prog);
    for (int i = 0; i < 8; i++) begin
      pressButton(5'b00010, 16'h0);
      checkOutput("wrap_up", 16'(prog), 16'((startVal + i + 1) % 8));
    end
    while (prog != 3'd0) pressButton(5'b00010, 16'h0);
    pressButton(5'b00100, 16'h0);
    checkOutput("wrap_down", 16'(prog), 16'h7);
    startVal = int'(gen_mod);
    for (int i = 0; i < 4; i++) begin
      pressButton(5'b01000, 16'h0);
      checkOutput("gen_up", 16'(gen_mod), 16'((startVal + i + 1) % 4));
    end
    while (gen_mod != 2'd0) pressButton(5'b01000, 16'h0);
    pressButton(5'b10000, 16'h0);
    checkOutput("gen_down", 16'(gen_mod), 16'h3);

    // Simultaneous presses.
    pressButton(5'b00110, 16'h0);
    checkOutput("ud_cancel", 16'(prog), 16'h7);
    startVal = int'(gen_mod);
    pressButton(5'b01001, 16'hBEEF);
    checkOutput("cr_gen", 16'(gen_mod), 16'((startVal + 1) % 4));
    checkOutput("cr_data", data_2, 16'hBEEF);

    // Capture, then switch changes without a press.
    validCount = 0;
    for (int i = 0; i < DEB + 4; i++) begin
      applyStimulus(1'b0, 5'b00001, 16'hA5C3);
      if (data_valid) validCount++;
    end
    for (int i = 0; i < DEB + 4; i++) begin
      applyStimulus(1'b0, 5'b00000, 16'hA5C3);
      if (data_valid) validCount++;
    end
    checkOutput("cap_data", data_2, 16'hA5C3);
    checkOutput("cap_pulses", 16'(validCount), 16'h1);
    validCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 5'b00000, 16'h1234);
      if (data_valid) validCount++;
    end
    checkOutput("sw_hold_data", data_2, 16'hA5C3);
    checkOutput("sw_hold_valid", 16'(validCount), 16'h0);

    // Reset in the middle of a debounce.
    applyStimulus(1'b0, 5'b00010, 16'h0);
    applyStimulus(1'b0, 5'b00010, 16'h0);
    applyStimulus(1'b1, 5'b00010, 16'h0);
    checkOutput("mid_rst_prog", 16'(prog), 16'h0);
    relEdge = edgeNo + 1;
    changeEdge = -1;
    for (int i = 0; i < DEB + 8; i++) begin
      applyStimulus(1'b0, 5'b00010, 16'h0);
      if (prog != 3'd0 && changeEdge < 0) changeEdge = edgeNo;
    end
    checkOutput("mid_rst_latency", 16'(changeEdge - relEdge), 16'(DEB + 2));
    checkOutput("mid_rst_final", 16'(prog), 16'h1);

    // Random activity with occasional resets.
    rb = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      applyStimulus(($urandom_range(0, 149) == 0), rb, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
